// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch path: NOP encoding, default
// reset PC, fetch FSM states and the IF/ID pipeline register layout.
package core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // Clears PC[1:0] so every fetch address is word aligned.
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    valid:    1'b0,
    pc:       32'h0000_0000,
    pc_plus4: 32'h0000_0000,
    instr:    NOP_INSTR
  };

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection for the fetch stage.
// Priority: redirect > BOOT hold > stall hold > fetch-disable hold > PC+4.
module fetch_pc_gen
  import core_pkg::*;
(
  input  logic [31:0]  pc,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         stall,
  input  logic         mem_en,
  input  fetch_state_t state,
  output logic [31:0]  next_pc
);

  // Select the PC for the next cycle; the sum wraps modulo 2^32 on its own.
  always_comb begin
    // NOTE: assign a default first so no path leaves next_pc unassigned, which would infer a latch.
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc & PC_ALIGN_MASK;
    end else if (state == BOOT || stall || !mem_en) begin
      next_pc = pc;
    end else begin
      next_pc = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/FETCH/HOLD control and the IF/ID
// pipeline register. Instruction memory is read combinationally at imem_addr,
// so a word addressed in cycle N lands in IF/ID at the end of cycle N.
// Optional statistics counters are built when macro FETCH_STATS_EN is defined.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mem_en,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             ifid_valid,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc_plus4,
  output logic [31:0]      ifid_instr
`ifdef FETCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] fetch_count
`endif
);

  // A zero-width counter cannot exist; reject it at elaboration.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fetch_stage: CNT_W must be at least 1");
  end

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  ifid_t        ifid;
  logic         do_load;

  assign pc_plus4 = pc + PC_STEP;

  // A real instruction enters IF/ID only in a steady cycle that is not
  // flushed, stalled, disabled or the post-reset BOOT cycle.
  assign do_load = !redirect_valid && (state != BOOT) && !stall && mem_en;

  fetch_pc_gen u_pc_gen (
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .mem_en         (mem_en),
    .state          (state),
    .next_pc        (next_pc)
  );

  // Fetch FSM with PC and IF/ID registers; reset forces BOOT, RESET_PC and a bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC & PC_ALIGN_MASK;
      ifid  <= IFID_BUBBLE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pc <= next_pc;
      if (redirect_valid) begin
        state <= FETCH;
        ifid  <= IFID_BUBBLE;
      end else if (state == BOOT) begin
        state <= FETCH;
        ifid  <= IFID_BUBBLE;
      end else if (stall) begin
        state <= HOLD;
      end else if (!mem_en) begin
        state <= FETCH;
        ifid  <= IFID_BUBBLE;
      end else begin
        state <= FETCH;
        ifid  <= '{valid: 1'b1, pc: pc, pc_plus4: pc_plus4, instr: imem_rdata};
      end
    end
  end

  assign imem_addr     = pc;
  assign ifid_valid    = ifid.valid;
  assign ifid_pc       = ifid.pc;
  assign ifid_pc_plus4 = ifid.pc_plus4;
  assign ifid_instr    = ifid.instr;

`ifdef FETCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Saturating event counters for stalls, flushes and valid IF/ID loads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
      fetch_count <= '0;
    end else begin
      if (stall && !redirect_valid && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_ONE;
      end
      if (redirect_valid && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_ONE;
      end
      if (do_load && (fetch_count != '1)) begin
        fetch_count <= fetch_count + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Statistics checks are compiled in when
// macro FETCH_STATS_EN is defined (counters built with CNT_W = 4).
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_en;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
`ifdef FETCH_STATS_EN
  logic [3:0]  stall_count;
  logic [3:0]  flush_count;
  logic [3:0]  fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Instruction memory image: the three program words, otherwise ~address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0000;
      32'h0000_0004: mem_word = 32'h0000_2483;
      32'h0000_0008: mem_word = 32'h0024_80B3;
      default:       mem_word = ~a;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_en         (mem_en),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_instr     (ifid_instr)
`ifdef FETCH_STATS_EN
    ,
    .stall_count    (stall_count),
    .flush_count    (flush_count),
    .fetch_count    (fetch_count)
`endif
  );

  // Advance one clock and settle 1 ns past the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hold reset two cycles, release just after an edge: the current cycle is BOOT.
  task automatic do_reset();
    reset = 1'b1; mem_en = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_en = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    if (imem_addr !== 32'h0) begin $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); errors++; end
    checks++;
    if ({ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr} !== 97'h0) begin
      $display("FAIL reset_bubble: got v=%b pc=%h pc4=%h instr=%h expected all zero", ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr);
      errors++;
    end
    checks++;
  endtask

  // Program fetch after BOOT: words 0, 0x2483, 0x2480B3 at PCs 0/4/8.
  task automatic test_fetch_seq();
    logic [31:0] exp_instr [3];
    exp_instr[0] = 32'h0000_0000; exp_instr[1] = 32'h0000_2483; exp_instr[2] = 32'h0024_80B3;
    do_reset();
    mem_en = 1'b1;
    step();  // BOOT cycle ends: still at RESET_PC with a bubble
    if (imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin
      $display("FAIL boot_cycle: got addr=%h valid=%b expected addr=0 valid=0", imem_addr, ifid_valid); errors++;
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      step();
      if ({ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr} !== {1'b1, 32'(4*i), 32'(4*i+4), exp_instr[i]}) begin
        $display("FAIL fetch_%0d: got v=%b pc=%h pc4=%h instr=%h expected v=1 pc=%h pc4=%h instr=%h",
                 i, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, 32'(4*i), 32'(4*i+4), exp_instr[i]);
        errors++;
      end
      checks++;
      if (imem_addr !== 32'(4*i+4)) begin $display("FAIL fetch_addr_%0d: got %h expected %h", i, imem_addr, 32'(4*i+4)); errors++; end
      checks++;
    end
  endtask

  // One-cycle stall while ifid_pc=4: PC and IF/ID hold, then PC 8 follows.
  task automatic test_stall();
    do_reset();
    mem_en = 1'b1;
    step(); step(); step();  // BOOT, fetch 0, fetch 4
    stall = 1'b1;
    step();
    if (ifid_pc !== 32'h4 || ifid_instr !== 32'h0000_2483 || ifid_valid !== 1'b1) begin
      $display("FAIL stall_hold_ifid: got pc=%h instr=%h v=%b expected pc=4 instr=00002483 v=1", ifid_pc, ifid_instr, ifid_valid); errors++;
    end
    checks++;
    if (imem_addr !== 32'h8) begin $display("FAIL stall_hold_addr: got %h expected %h", imem_addr, 32'h8); errors++; end
    checks++;
    stall = 1'b0;
    step();
    if (ifid_pc !== 32'h8 || ifid_instr !== 32'h0024_80B3 || imem_addr !== 32'hC) begin
      $display("FAIL stall_resume: got pc=%h instr=%h addr=%h expected pc=8 instr=002480b3 addr=c", ifid_pc, ifid_instr, imem_addr); errors++;
    end
    checks++;
  endtask

  // Redirect to 0x20 with stall also high: redirect wins and flushes IF/ID.
  task automatic test_redirect_over_stall();
    redirect_valid = 1'b1; redirect_pc = 32'h20; stall = 1'b1;
    step();
    if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== 32'h0 || imem_addr !== 32'h20) begin
      $display("FAIL redirect_flush: got v=%b pc=%h instr=%h addr=%h expected v=0 pc=0 instr=0 addr=20", ifid_valid, ifid_pc, ifid_instr, imem_addr); errors++;
    end
    checks++;
    redirect_valid = 1'b0; stall = 1'b0;
    step();
    if ({ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr} !== {1'b1, 32'h20, 32'h24, 32'hFFFF_FFDF}) begin
      $display("FAIL redirect_target: got v=%b pc=%h pc4=%h instr=%h expected v=1 pc=20 pc4=24 instr=ffffffdf", ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr); errors++;
    end
    checks++;
  endtask

  // Misaligned redirect is word aligned; PC wraps at the top of the address space.
  task automatic test_align_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'h23;
    step();
    if (imem_addr !== 32'h20) begin $display("FAIL align_addr: got %h expected %h", imem_addr, 32'h20); errors++; end
    checks++;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    if (imem_addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_addr0: got %h expected %h", imem_addr, 32'hFFFF_FFFC); errors++; end
    checks++;
    redirect_valid = 1'b0;
    step();
    if (imem_addr !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC || ifid_pc_plus4 !== 32'h0) begin
      $display("FAIL wrap_addr1: got addr=%h pc=%h pc4=%h expected addr=0 pc=fffffffc pc4=0", imem_addr, ifid_pc, ifid_pc_plus4); errors++;
    end
    checks++;
    step();
    if (imem_addr !== 32'h4) begin $display("FAIL wrap_addr2: got %h expected %h", imem_addr, 32'h4); errors++; end
    checks++;
  endtask

  // mem_en low: PC holds and a bubble enters IF/ID; fetch resumes afterwards.
  task automatic test_mem_en_bubble();
    mem_en = 1'b0;
    step();
    if (imem_addr !== 32'h4 || ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== 32'h0) begin
      $display("FAIL memen_bubble: got addr=%h v=%b pc=%h instr=%h expected addr=4 v=0 pc=0 instr=0", imem_addr, ifid_valid, ifid_pc, ifid_instr); errors++;
    end
    checks++;
    mem_en = 1'b1;
    step();
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4 || ifid_instr !== 32'h0000_2483 || imem_addr !== 32'h8) begin
      $display("FAIL memen_resume: got v=%b pc=%h instr=%h addr=%h expected v=1 pc=4 instr=00002483 addr=8", ifid_valid, ifid_pc, ifid_instr, imem_addr); errors++;
    end
    checks++;
  endtask

  // Reset during HOLD takes effect before the next edge; BOOT then lasts one cycle.
  task automatic test_reset_mid_hold();
    stall = 1'b1;
    step();  // now in HOLD at imem_addr 8
    reset = 1'b1;
    #1;
    if (imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin
      $display("FAIL async_reset: got addr=%h v=%b expected addr=0 v=0", imem_addr, ifid_valid); errors++;
    end
    checks++;
    stall = 1'b0;
    step();
    reset = 1'b0;  // BOOT cycle begins
    step();
    if (imem_addr !== 32'h0 || ifid_valid !== 1'b0) begin
      $display("FAIL reset_boot: got addr=%h v=%b expected addr=0 v=0", imem_addr, ifid_valid); errors++;
    end
    checks++;
    step();
    if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || imem_addr !== 32'h4) begin
      $display("FAIL reset_first_fetch: got v=%b pc=%h addr=%h expected v=1 pc=0 addr=4", ifid_valid, ifid_pc, imem_addr); errors++;
    end
    checks++;
  endtask

`ifdef FETCH_STATS_EN
  // Counters: stall saturates at 15 with CNT_W=4, flushes and fetches count exactly.
  task automatic test_stats();
    do_reset();
    mem_en = 1'b1; stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    if (stall_count !== 4'd15) begin $display("FAIL stall_count_sat: got %0d expected %0d", stall_count, 15); errors++; end
    checks++;
    stall = 1'b0;
    step();  // one real fetch from HOLD
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'b1; redirect_pc = 32'(16 * (i + 1));
      step();
    end
    redirect_valid = 1'b0;
    if (flush_count !== 4'd3) begin $display("FAIL flush_count: got %0d expected %0d", flush_count, 3); errors++; end
    checks++;
    if (fetch_count !== 4'd1) begin $display("FAIL fetch_count: got %0d expected %0d", fetch_count, 1); errors++; end
    checks++;
    reset = 1'b1;
    #1;
    if ({stall_count, flush_count, fetch_count} !== 12'h0) begin
      $display("FAIL stats_reset: got %0d/%0d/%0d expected 0/0/0", stall_count, flush_count, fetch_count); errors++;
    end
    checks++;
    step();
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_seq();
    test_stall();
    test_redirect_over_stall();
    test_align_wrap();
    test_mem_en_bubble();
    test_reset_mid_hold();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Runaway guard: the directed sequence needs only a few hundred ns.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "testbench timeout");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters.
REQ-003 Port clock  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset; one clock domain only.
REQ-005 Port mem_en  input  1  fetch enable; low means PC hold and bubble insertion.
REQ-006 Port stall  input  1  load-use stall from decode; hold PC and IF/ID.
REQ-007 Port redirect_valid  input  1  taken jump/branch from execute.
REQ-008 Port redirect_pc  input  32  redirect target.
REQ-009 Port imem_addr  output  32  byte address to instruction memory, equal to the PC register.
REQ-010 Port imem_rdata  input  32  word at imem_addr, big-endian (byte addr+0 = bits 31:24), valid combinationally in the same cycle.
REQ-011 Ports ifid_valid (1), ifid_pc (32), ifid_pc_plus4 (32), ifid_instr (32): outputs, IF/ID pipeline register contents.

Function
REQ-012 The state machine SHALL have three states: BOOT, FETCH, HOLD.
REQ-013 BOOT is entered on reset and SHALL last exactly one cycle after reset deassertion: PC stays RESET_PC, IF/ID holds a bubble, next state FETCH.
REQ-014 In FETCH, mem_en=1, stall=0, redirect_valid=0: IF/ID <= {1, PC, PC+4, imem_rdata}; PC <= PC+4.
REQ-015 Fetch latency SHALL be one cycle: word addressed by imem_addr in cycle N appears on ifid_instr in cycle N+1.
REQ-016 stall=1 without redirect SHALL hold PC and all IF/ID fields unchanged and move to HOLD; HOLD returns to FETCH in the first cycle with stall=0.
REQ-017 mem_en=0 without redirect or stall SHALL hold PC and load a bubble into IF/ID.
REQ-018 Priority SHALL be reset > redirect_valid > stall > mem_en=0 > normal fetch.
REQ-019 redirect_valid=1 in any state SHALL set PC <= {redirect_pc[31:2], 2'b00}, load a bubble into IF/ID, and move to FETCH, even if stall=1.
REQ-020 A bubble SHALL be ifid_valid=0, ifid_instr=NOP_INSTR (32'h0000_0000), ifid_pc=0, ifid_pc_plus4=0.
REQ-021 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error signalled.
REQ-022 PC[1:0] SHALL always be 2'b00.

Reset
REQ-023 Asserting reset at any time, including mid-stall or mid-redirect, SHALL immediately force state BOOT, PC=RESET_PC (imem_addr=RESET_PC), and an IF/ID bubble.
REQ-024 Asserting reset SHALL clear all statistics counters to 0 when they are present.

Configuration
REQ-025 With macro FETCH_STATS_EN defined, the block SHALL add outputs stall_count, flush_count and fetch_count, each CNT_W bits wide.
REQ-026 Increment rules: stall_count on each cycle with stall=1 and no redirect; flush_count on each redirect_valid=1 cycle; fetch_count on each valid IF/ID load. Each counter saturates at all-ones and does not wrap.
REQ-027 Without FETCH_STATS_EN, those ports and their counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package core_pkg SHALL hold NOP_INSTR, the RESET_PC default, and the enum fetch_state_t {BOOT, FETCH, HOLD}.
REQ-029 Next-PC selection SHALL be a combinational sub-module fetch_pc_gen.
- Inputs: PC, redirect_valid, redirect_pc, stall, mem_en, state.
- Output: next PC.
REQ-030 The state register, PC register, IF/ID register and counters SHALL reside in fetch_stage.

Verification
REQ-031 Reset, then mem_en=1 with words NOP, 32'h0000_2483, 32'h0024_80B3 at addresses 0/4/8 -> after the BOOT cycle, ifid_instr sequence is 0, 0x00002483, 0x002480B3, with ifid_pc 0/4/8 and ifid_valid=1.
REQ-032 stall=1 for 1 cycle while ifid_pc=4 -> ifid_pc stays 4 and imem_addr stays 8 for that cycle, then ifid_pc=8 follows.
REQ-033 redirect_valid=1, redirect_pc=0x20, with stall=1 asserted in the same cycle -> next cycle: ifid_valid=0, imem_addr=0x20; following cycle: ifid_pc=0x20.
REQ-034 redirect_pc=0x23 -> imem_addr=0x20; redirect_pc=0xFFFFFFFC followed by two normal fetches -> imem_addr sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-035 Reset pulsed mid-HOLD -> imem_addr=RESET_PC and ifid_valid=0 immediately (before the next clock edge); BOOT lasts one cycle after deassertion.
REQ-036 With FETCH_STATS_EN, CNT_W=4: 20 stall cycles -> stall_count=15; flush_count counts 3 redirects as 3.
